// File: rtl/conv_param_loader_pkg.sv
// conv_param_loader_pkg: loader FSM state encodings and per-layer default geometry.
package conv_param_loader_pkg;

    typedef enum logic [2:0] {
        S_LOAD_W  = 3'd0,
        S_DRAIN_W = 3'd1,
        S_LOAD_B  = 3'd2,
        S_DRAIN_B = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam int DEF_NUM_CH   = 6;
    localparam int DEF_KERNEL_K = 5;
    localparam int DEF_W_WIDTH  = 8;
    localparam int DEF_B_WIDTH  = 32;

endpackage

// File: rtl/conv_param_loader_rom_tag_pipe.sv
// conv_param_loader_rom_tag_pipe: LAT+1 stage {valid, index} shift register that tracks each ROM read
// until its data is due, so the capture side knows which bank slot the word belongs to.
module conv_param_loader_rom_tag_pipe #(
    parameter int LAT = 1,
    parameter int IW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          v_i,
    input  logic [IW-1:0] idx_i,
    output logic          v_o,
    output logic [IW-1:0] idx_o
);

    logic [LAT:0]         v_q;
    logic [LAT:0][IW-1:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            idx_q <= '0;
        end else begin
            v_q[0]   <= v_i;
            idx_q[0] <= idx_i;
            for (int k = 1; k <= LAT; k++) begin
                v_q[k]   <= v_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    assign v_o   = v_q[LAT];
    assign idx_o = idx_q[LAT];

endmodule

// File: rtl/conv_param_loader.sv
// conv_param_loader: streams conv weights and biases from two synchronous ROMs into flat banks and
// gates pixel valid until loaded. Define CONV_LOADER_CHECKSUM_EN to add the running checksum port.
module conv_param_loader
    import conv_param_loader_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int KERNEL_K = DEF_KERNEL_K,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    parameter int B_WIDTH  = DEF_B_WIDTH,
    parameter int ROM_LAT  = 1,
    parameter int W_ADDR_W = 8,
    parameter int B_ADDR_W = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              reload_i,
    output logic [W_ADDR_W-1:0]               w_rom_addr_o,
    input  logic [W_WIDTH-1:0]                w_rom_q_i,
    output logic [B_ADDR_W-1:0]               b_rom_addr_o,
    input  logic [B_WIDTH-1:0]                b_rom_q_i,
    output logic [NUM_CH*KERNEL_K*KERNEL_K*W_WIDTH-1:0] weights_flat_o,
    output logic [NUM_CH*B_WIDTH-1:0]         biases_flat_o,
    output logic                              busy_o,
    output logic                              ready_o,
    output logic                              load_done_o,
    input  logic                              valid_in_i,
    output logic                              valid_out_o
`ifdef CONV_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                       checksum_o
`endif
);

    localparam int TAPS  = KERNEL_K * KERNEL_K;
    localparam int N_W   = NUM_CH * TAPS;
    localparam int N_B   = NUM_CH;
    localparam int DRAIN = ROM_LAT + 1;

    state_e              state_q, state_d;
    logic [15:0]         idx_q, idx_d;
    logic [W_ADDR_W-1:0] w_addr_q, w_addr_d, w_tag;
    logic [B_ADDR_W-1:0] b_addr_q, b_addr_d, b_tag;
    logic                w_tag_v, b_tag_v, w_issue, b_issue;
    logic                busy_q, busy_d, ready_q, ready_d, done_q, done_d;
    logic [N_W*W_WIDTH-1:0] w_bank_q;
    logic [N_B*B_WIDTH-1:0] b_bank_q;

    always_comb begin
        w_issue  = state_q == S_LOAD_W;
        b_issue  = state_q == S_LOAD_B;
        w_addr_d = w_issue ? idx_q[W_ADDR_W-1:0] : w_addr_q;
        b_addr_d = b_issue ? idx_q[B_ADDR_W-1:0] : b_addr_q;
        state_d  = state_q;
        idx_d    = idx_q + 16'd1;
        unique case (state_q)
            S_LOAD_W:  if (idx_q == 16'(N_W - 1))   begin state_d = S_DRAIN_W; idx_d = '0; end
            S_DRAIN_W: if (idx_q == 16'(DRAIN - 1)) begin state_d = S_LOAD_B;  idx_d = '0; end
            S_LOAD_B:  if (idx_q == 16'(N_B - 1))   begin state_d = S_DRAIN_B; idx_d = '0; end
            S_DRAIN_B: if (idx_q == 16'(DRAIN - 1)) begin state_d = S_DONE;    idx_d = '0; end
            S_DONE: begin
                idx_d = '0;
                if (reload_i) state_d = S_LOAD_W;
            end
            default: begin
                state_d = S_LOAD_W;
                idx_d   = '0;
            end
        endcase
        busy_d  = state_d != S_DONE;
        ready_d = state_d == S_DONE;
        done_d  = ready_d && state_q != S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_LOAD_W;
            idx_q    <= '0;
            w_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            w_addr_q <= w_addr_d;
            b_addr_q <= b_addr_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Tags enter on the same edge that registers the address, so they emerge exactly when data is due.
    conv_param_loader_rom_tag_pipe #(.LAT(ROM_LAT), .IW(W_ADDR_W)) u_w_tags (
        .clk   (clk),
        .rst   (rst),
        .v_i   (w_issue),
        .idx_i (idx_q[W_ADDR_W-1:0]),
        .v_o   (w_tag_v),
        .idx_o (w_tag)
    );

    conv_param_loader_rom_tag_pipe #(.LAT(ROM_LAT), .IW(B_ADDR_W)) u_b_tags (
        .clk   (clk),
        .rst   (rst),
        .v_i   (b_issue),
        .idx_i (idx_q[B_ADDR_W-1:0]),
        .v_o   (b_tag_v),
        .idx_o (b_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_bank_q <= '0;
            b_bank_q <= '0;
        end else begin
            if (w_tag_v) w_bank_q[int'(w_tag)*W_WIDTH +: W_WIDTH] <= w_rom_q_i;
            if (b_tag_v) b_bank_q[int'(b_tag)*B_WIDTH +: B_WIDTH] <= b_rom_q_i;
        end
    end

`ifdef CONV_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else if (state_q == S_DONE && reload_i)
            sum_q <= '0;
        else
            sum_q <= sum_q + (w_tag_v ? 32'(signed'(w_rom_q_i)) : 32'd0)
                           + (b_tag_v ? 32'(signed'(b_rom_q_i)) : 32'd0);
    end

    assign checksum_o = sum_q;
`endif

    assign w_rom_addr_o   = w_addr_q;
    assign b_rom_addr_o   = b_addr_q;
    assign weights_flat_o = w_bank_q;
    assign biases_flat_o  = b_bank_q;
    assign busy_o         = busy_q;
    assign ready_o        = ready_q;
    assign load_done_o    = done_q;
    assign valid_out_o    = valid_in_i & ready_q;

endmodule

// File: tb/tb_conv_param_loader.sv
// tb_conv_param_loader: drives two loader instances (default geometry and a 16ch/3x3/latency-2 build)
// from behavioural ROMs and checks banks, timing and gating against the ROM contents.
module tb_conv_param_loader;

    localparam int NW1 = 6 * 5 * 5;
    localparam int NB1 = 6;
    localparam int RDY1 = NW1 + NB1 + 2 * (1 + 1);
    localparam int NW2 = 16 * 3 * 3;
    localparam int NB2 = 16;
    localparam int RDY2 = NW2 + NB2 + 2 * (2 + 1);

    logic clk = 1'b0;
    logic rst, rst2, reload, reload2, valid_in;
    always #5 clk = ~clk;

    logic [7:0] w_addr1, wq1, w_addr2, wq2, wq2a;
    logic [2:0] b_addr1;
    logic [3:0] b_addr2;
    logic [31:0] bq1, bq2, bq2a;
    logic [NW1*8-1:0] wf1;
    logic [NB1*32-1:0] bf1;
    logic [NW2*8-1:0] wf2;
    logic [NB2*32-1:0] bf2;
    logic busy1, ready1, done1, vout1, busy2, ready2, done2, vout2;
`ifdef CONV_LOADER_CHECKSUM_EN
    logic [31:0] cs1, cs2;
`endif

    logic [7:0]  wmem1[256];
    logic [7:0]  wmem2[256];
    logic [31:0] bmem1[8];
    logic [31:0] bmem2[16];

    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        wq1  <= wmem1[w_addr1];
        bq1  <= bmem1[b_addr1];
        wq2a <= wmem2[w_addr2];
        wq2  <= wq2a;
        bq2a <= bmem2[b_addr2];
        bq2  <= bq2a;
    end

    conv_param_loader dut1 (
        .clk(clk), .rst(rst), .reload_i(reload),
        .w_rom_addr_o(w_addr1), .w_rom_q_i(wq1), .b_rom_addr_o(b_addr1), .b_rom_q_i(bq1),
        .weights_flat_o(wf1), .biases_flat_o(bf1), .busy_o(busy1), .ready_o(ready1),
        .load_done_o(done1), .valid_in_i(valid_in), .valid_out_o(vout1)
`ifdef CONV_LOADER_CHECKSUM_EN
        , .checksum_o(cs1)
`endif
    );

    conv_param_loader #(.NUM_CH(16), .KERNEL_K(3), .ROM_LAT(2), .W_ADDR_W(8), .B_ADDR_W(4)) dut2 (
        .clk(clk), .rst(rst2), .reload_i(reload2),
        .w_rom_addr_o(w_addr2), .w_rom_q_i(wq2), .b_rom_addr_o(b_addr2), .b_rom_q_i(bq2),
        .weights_flat_o(wf2), .biases_flat_o(bf2), .busy_o(busy2), .ready_o(ready2),
        .load_done_o(done2), .valid_in_i(valid_in), .valid_out_o(vout2)
`ifdef CONV_LOADER_CHECKSUM_EN
        , .checksum_o(cs2)
`endif
    );

    // Number of bank slots that disagree with the ROM contents.
    function automatic int bad1();
        int n = 0;
        for (int i = 0; i < NW1; i++) if (wf1[i*8 +: 8] !== wmem1[i]) n++;
        for (int c = 0; c < NB1; c++) if (bf1[c*32 +: 32] !== bmem1[c]) n++;
        return n;
    endfunction

    function automatic int bad2();
        int n = 0;
        for (int i = 0; i < NW2; i++) if (wf2[i*8 +: 8] !== wmem2[i]) n++;
        for (int c = 0; c < NB2; c++) if (bf2[c*32 +: 32] !== bmem2[c]) n++;
        return n;
    endfunction

    function automatic logic [31:0] sum1();
        int s = 0;
        for (int i = 0; i < NW1; i++) s += int'($signed(wmem1[i]));
        for (int c = 0; c < NB1; c++) s += int'($signed(bmem1[c]));
        return 32'(s);
    endfunction

    function automatic logic [31:0] sum2();
        int s = 0;
        for (int i = 0; i < NW2; i++) s += int'($signed(wmem2[i]));
        for (int c = 0; c < NB2; c++) s += int'($signed(bmem2[c]));
        return 32'(s);
    endfunction

    task automatic test_reset();
        reload = 0; reload2 = 0; valid_in = 1;
        rst = 0; rst2 = 0;
        #1 rst = 1; rst2 = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({ready1, busy1, done1} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags1 ready/busy/done=%b required 000", {ready1, busy1, done1});
        end
        n_chk++;
        if (wf1 !== '0 || bf1 !== '0) begin
            n_fail++; $display("FAIL reset_banks1 got nonzero bank, required all zero");
        end
        n_chk++;
        if (w_addr1 !== 8'd0 || b_addr1 !== 3'd0) begin
            n_fail++; $display("FAIL reset_addr1 w=%0d b=%0d required 0/0", w_addr1, b_addr1);
        end
        n_chk++;
        if (vout1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_out got %b required 0", vout1);
        end
        n_chk++;
        if ({ready2, busy2, done2} !== 3'b000 || wf2 !== '0 || bf2 !== '0) begin
            n_fail++; $display("FAIL reset_dut2 ready/busy/done=%b required 000 with zero banks", {ready2, busy2, done2});
        end
    endtask

    task automatic test_load();
        int rdy_at = -1, done_at = -1, n_done = 0;
        logic [7:0] exp_w = 8'(-18);
        for (int i = 0; i < NW1; i++) wmem1[i] = 8'(i - 75);
        for (int c = 0; c < NB1; c++) bmem1[c] = 32'(1000 * c - 2500);
        valid_in = 1;
        @(negedge clk) rst = 0;
        for (int k = 1; k <= RDY1 + 5; k++) begin
            @(posedge clk); #1;
            if (done1) begin n_done++; done_at = k; end
            if (ready1 && rdy_at < 0) rdy_at = k;
            if (k == 1) begin
                n_chk++;
                if (busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_first_edge got %b required 1", busy1); end
            end
            n_chk++;
            if (vout1 !== (k >= RDY1)) begin
                n_fail++; $display("FAIL valid_gate edge %0d got %b required %b", k, vout1, k >= RDY1);
            end
        end
        n_chk++;
        if (rdy_at !== RDY1) begin n_fail++; $display("FAIL ready_edge got %0d required %0d", rdy_at, RDY1); end
        n_chk++;
        if (n_done !== 1 || done_at !== RDY1) begin
            n_fail++; $display("FAIL load_done_pulse count=%0d at=%0d required 1 at %0d", n_done, done_at, RDY1);
        end
        n_chk++;
        if (wf1[(2*25+7)*8 +: 8] !== exp_w) begin
            n_fail++; $display("FAIL ch2_tap7 got %0d required -18", $signed(wf1[(2*25+7)*8 +: 8]));
        end
        n_chk++;
        if (bf1[5*32 +: 32] !== 32'd2500) begin
            n_fail++; $display("FAIL bias_ch5 got %0d required 2500", $signed(bf1[5*32 +: 32]));
        end
        n_chk++;
        if (bad1() != 0) begin n_fail++; $display("FAIL banks_load1 mismatched=%0d required 0", bad1()); end
        n_chk++;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_done got %b required 0", busy1); end
    endtask

`ifdef CONV_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        n_chk++;
        if (cs1 !== sum1()) begin n_fail++; $display("FAIL checksum1 got %h required %h", cs1, sum1()); end
    endtask
`endif

    task automatic test_reload();
        logic [7:0] prevw[NW1];
        logic [31:0] prevb[NB1];
        int rdy_at = -1, nbad = 0;
        for (int i = 0; i < NW1; i++) begin prevw[i] = wmem1[i]; wmem1[i] = ~8'(i); end
        for (int c = 0; c < NB1; c++) begin prevb[c] = bmem1[c]; bmem1[c] = $urandom; end
        @(negedge clk) reload = 1;
        @(posedge clk); #1;
        reload = 0;
        n_chk++;
        if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL reload_flags ready=%b busy=%b required 0/1", ready1, busy1);
        end
        for (int i = 0; i < NW1; i++) if (wf1[i*8 +: 8] !== prevw[i]) nbad++;
        for (int c = 0; c < NB1; c++) if (bf1[c*32 +: 32] !== prevb[c]) nbad++;
        n_chk++;
        if (nbad != 0) begin n_fail++; $display("FAIL reload_keeps_old mismatched=%0d required 0", nbad); end
        for (int k = 1; k <= 400; k++) begin
            reload = (k == 50);
            @(posedge clk); #1;
            if (ready1) begin rdy_at = k; break; end
        end
        reload = 0;
        n_chk++;
        if (rdy_at !== RDY1) begin n_fail++; $display("FAIL reload_ready_edge got %0d required %0d", rdy_at, RDY1); end
        n_chk++;
        if (bad1() != 0) begin n_fail++; $display("FAIL banks_reload mismatched=%0d required 0", bad1()); end
`ifdef CONV_LOADER_CHECKSUM_EN
        n_chk++;
        if (cs1 !== sum1()) begin n_fail++; $display("FAIL checksum_reload got %h required %h", cs1, sum1()); end
`endif
    endtask

    task automatic test_rst_mid();
        int rdy_at = -1;
        for (int i = 0; i < NW1; i++) wmem1[i] = 8'($urandom);
        for (int c = 0; c < NB1; c++) bmem1[c] = $urandom;
        @(negedge clk) reload = 1;
        @(posedge clk); #1;
        reload = 0;
        repeat (80) @(posedge clk);
        @(negedge clk); #2;
        rst = 1;
        #1;
        n_chk++;
        if (wf1 !== '0 || bf1 !== '0 || ready1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL async_rst ready=%b busy=%b banks_zero=%b required 0/0/1",
                               ready1, busy1, (wf1 == '0 && bf1 == '0));
        end
        @(negedge clk) rst = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (ready1) begin rdy_at = k; break; end
        end
        n_chk++;
        if (rdy_at !== RDY1) begin n_fail++; $display("FAIL rst_ready_edge got %0d required %0d", rdy_at, RDY1); end
        n_chk++;
        if (bad1() != 0) begin n_fail++; $display("FAIL banks_after_rst mismatched=%0d required 0", bad1()); end
    endtask

    task automatic test_params();
        int rdy_at = -1;
        for (int i = 0; i < NW2; i++) wmem2[i] = 8'($urandom);
        for (int c = 0; c < NB2; c++) bmem2[c] = $urandom;
        @(negedge clk) rst2 = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (ready2) begin rdy_at = k; break; end
        end
        n_chk++;
        if (rdy_at !== RDY2) begin n_fail++; $display("FAIL params_ready_edge got %0d required %0d", rdy_at, RDY2); end
        n_chk++;
        if (bad2() != 0) begin n_fail++; $display("FAIL banks_params mismatched=%0d required 0", bad2()); end
        n_chk++;
        if (vout2 !== 1'b1) begin n_fail++; $display("FAIL params_valid_out got %b required 1", vout2); end
`ifdef CONV_LOADER_CHECKSUM_EN
        n_chk++;
        if (cs2 !== sum2()) begin n_fail++; $display("FAIL checksum2 got %h required %h", cs2, sum2()); end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
`ifdef CONV_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reload();
        test_rst_mid();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
